// File: rtl/weight_loader_pkg.sv
// Shared definitions for the weight loader and the weight register bank it feeds.
// Used by weight_loader.sv; the checksum stage is controlled by WEIGHT_LOADER_CHECKSUM_EN.
package weight_loader_pkg;

  localparam int          DATA_W_DEF    = 8;
  localparam int          ADDR_W_DEF    = 2;
  localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    LOAD,
    CHECK,
    FIN
  } state_t;

endpackage

// File: rtl/weight_loader.sv
// Framed byte-stream to weight-bank write initiator: sync byte, NUM_WEIGHTS weights, optional checksum.
// Define WEIGHT_LOADER_CHECKSUM_EN to require and verify a trailing checksum byte.
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int                DATA_W      = DATA_W_DEF,
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter int                NUM_WEIGHTS = 4,
  parameter logic [DATA_W-1:0] SYNC_BYTE   = DATA_W'(SYNC_BYTE_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WEIGHTS - 1);

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  localparam state_t AFTER_LOAD = CHECK;
`else
  localparam state_t AFTER_LOAD = FIN;
`endif

  state_t            state, state_next;
  logic [ADDR_W-1:0] idx;
  logic              xfer;
  logic              err_sync;

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
  logic              match;
`endif

  assign in_ready = (state == SYNC) || (state == LOAD) || (state == CHECK);
  assign xfer     = in_valid && in_ready;
  assign busy     = (state != IDLE);

`ifdef WEIGHT_LOADER_CHECKSUM_EN
  assign done = (state == FIN) && match;
  assign err  = err_sync || ((state == FIN) && !match);
`else
  assign done = (state == FIN);
  assign err  = err_sync;
`endif

  always_comb begin
    // NOTE: default assigned first so every path drives state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SYNC;
      SYNC:    if (xfer) state_next = (in_data == SYNC_BYTE) ? LOAD : IDLE;
      LOAD:    if (xfer && (idx == LAST_IDX)) state_next = AFTER_LOAD;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      CHECK:   if (xfer) state_next = FIN;
`endif
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      wr_data  <= '0;
      wr_addr  <= '0;
      wr_en    <= 1'b0;
      err_sync <= 1'b0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      sum      <= '0;
      match    <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      wr_en    <= 1'b0;
      err_sync <= 1'b0;
      if (xfer) begin
        case (state)
          SYNC: begin
            if (in_data == SYNC_BYTE) begin
              idx <= '0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
              sum <= '0;
`endif
            end else begin
              err_sync <= 1'b1;
            end
          end
          LOAD: begin
            // wr_data/wr_addr only move on a write, so they hold while wr_en is low.
            wr_data <= in_data;
            wr_addr <= idx;
            wr_en   <= 1'b1;
            idx     <= idx + 1'b1;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
            sum     <= sum + in_data;
`endif
          end
`ifdef WEIGHT_LOADER_CHECKSUM_EN
          CHECK:   match <= (in_data == sum);
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: a frame-level model predicts bank writes and done/err pulses,
// a negedge monitor compares them; honours WEIGHT_LOADER_CHECKSUM_EN like the design.
module tb_weight_loader;
  import weight_loader_pkg::*;

  localparam int NUM = 4;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, start, in_valid;
  logic [7:0] in_data;
  logic       in_ready, wr_en, busy, done, err;
  logic [7:0] wr_data;
  logic [1:0] wr_addr;

  weight_loader #(.NUM_WEIGHTS(NUM)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [1:0] addr; logic [7:0] data; int cyc; } wr_exp_t;
  typedef struct { bit is_done; int cyc; } res_exp_t;

  wr_exp_t    wr_q[$];
  res_exp_t   res_q[$];
  wr_exp_t    mon_w;
  res_exp_t   mon_r;
  logic [7:0] bank[NUM];
  logic [7:0] model_bank[NUM];
  logic [7:0] frm[$];
  int         tests = 0;
  int         fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // The weight bank: a plain register array written on wr_en.
  always @(posedge clk) if (wr_en) bank[wr_addr] <= wr_data;

  // Monitor: every write strobe and every done/err pulse must match the head of its queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en) begin
        if (wr_q.size() == 0) check("wr_unexpected", 32'(wr_en), 32'd0);
        else begin
          mon_w = wr_q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(mon_w.addr));
          check("wr_data", 32'(wr_data), 32'(mon_w.data));
          check("wr_latency", 32'(cyc), 32'(mon_w.cyc));
        end
      end
      if (done || err) begin
        if (res_q.size() == 0) check("pulse_unexpected", 32'({done, err}), 32'd0);
        else begin
          mon_r = res_q.pop_front();
          check("done", 32'(done), 32'(mon_r.is_done));
          check("err", 32'(err), 32'(!mon_r.is_done));
          check("pulse_cycle", 32'(cyc), 32'(mon_r.cyc));
        end
      end
    end
  end

  task automatic make_frame(input logic [7:0] sync, input logic [31:0] w, input bit bad_ck,
                            input logic [7:0] bad_val);
    logic [7:0] s = 8'h00;
    frm.delete();
    frm.push_back(sync);
    for (int i = 0; i < NUM; i++) begin
      frm.push_back(w[31-8*i -: 8]);
      s = s + w[31-8*i -: 8];
    end
    if (CK) frm.push_back(bad_ck ? bad_val : s);
  endtask

  // Streams frm; abort_after>0 sends only that many bytes and expects no frame outcome.
  task automatic send_frame(input int stall_pct, input bit rand_start, input int abort_after);
    bit         good_sync = (frm[0] == SYNC_BYTE_DEF);
    int         nsend     = good_sync ? frm.size() : 1;
    logic [7:0] s         = 8'h00;
    bit         ok_done;
    for (int i = 1; i <= NUM; i++) s = s + frm[i];
    ok_done = good_sync && (!CK || frm[NUM+1] == s);
    if (abort_after > 0) nsend = abort_after;

    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < nsend; i++) begin
      int waited = 0;
      bit acc    = 1'b0;
      while (!acc) begin
        in_valid = ($urandom_range(99) >= stall_pct);
        in_data  = in_valid ? frm[i] : 8'($urandom);
        if (rand_start) start = ($urandom_range(3) == 0);
        @(negedge clk);
        if (in_valid && in_ready) begin
          acc = 1'b1;
          if (good_sync && i >= 1 && i <= NUM) begin
            wr_q.push_back('{addr: 2'(i-1), data: frm[i], cyc: cyc + 1});
            model_bank[i-1] = frm[i];
          end
          if (i == nsend - 1 && abort_after == 0) res_q.push_back('{is_done: ok_done, cyc: cyc + 1});
        end else if (++waited > 50) begin
          check("accept_timeout", 32'(waited), 32'd0);
          in_valid = 1'b0;
          start    = 1'b0;
          return;
        end
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    // A start during the done cycle must not retrigger the loader.
    start = rand_start && good_sync && abort_after == 0 && ($urandom_range(1) == 1);
  endtask

  task automatic post_frame(input string tag);
    @(posedge clk); #1 start = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h55;
    @(negedge clk);
    check({tag, "_idle_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check({tag, "_wr_pending"}, 32'(wr_q.size()), 32'd0);
    check({tag, "_res_pending"}, 32'(res_q.size()), 32'd0);
    for (int i = 0; i < NUM; i++)
      check($sformatf("%s_bank%0d", tag, i), 32'(bank[i]), 32'(model_bank[i]));
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_outputs", 32'({in_ready, wr_en, busy, done, err}), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    for (int i = 0; i < NUM; i++) begin
      bank[i]       = 8'h00;
      model_bank[i] = 8'h00;
    end
    do_reset();

    make_frame(8'hA5, 32'h11223344, 1'b0, 8'h00);
    send_frame(0, 1'b0, 0);
    post_frame("basic");

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    make_frame(8'hA5, 32'h01020304, 1'b1, 8'h00);
    send_frame(0, 1'b0, 0);
    post_frame("bad_ck");
`endif

    make_frame(8'h5A, 32'h0, 1'b0, 8'h00);
    send_frame(0, 1'b0, 0);
    post_frame("bad_sync");
    make_frame(8'hA5, 32'hC1C2C3C4, 1'b0, 8'h00);
    send_frame(0, 1'b0, 0);
    post_frame("after_bad_sync");

    make_frame(8'hA5, 32'h11223344, 1'b0, 8'h00);
    send_frame(50, 1'b0, 0);
    post_frame("stall");

    // Reset after the second weight: those two writes land, then a fresh frame loads.
    make_frame(8'hA5, 32'h99989796, 1'b0, 8'h00);
    send_frame(0, 1'b0, 3);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_outputs", 32'({in_ready, wr_en, busy, done, err}), 32'd0);
    check("midrst_wr_q", 32'(wr_q.size()), 32'd0);
    make_frame(8'hA5, 32'h55667788, 1'b0, 8'h00);
    send_frame(0, 1'b0, 0);
    post_frame("after_rst");

    for (int f = 0; f < 30; f++) begin
      logic [7:0] sy  = 8'hA5;
      logic [7:0] bad = 8'($urandom_range(255, 1));
      if ($urandom_range(5) == 0) begin
        sy = 8'($urandom);
        if (sy == 8'hA5) sy = 8'h5A;
      end
      make_frame(sy, $urandom, ($urandom_range(3) == 0), 8'h00);
      // A wrong checksum is the correct one with some bits flipped.
      if (CK && frm.size() == NUM + 2 && $urandom_range(3) == 0) frm[NUM+1] = frm[NUM+1] ^ bad;
      send_frame(int'($urandom_range(60)), 1'b1, 0);
      post_frame($sformatf("rand%0d", f));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
